// File: rtl/sfr_port_bank.sv
// sfr_port_bank: parametrised SFR-mapped I/O port bank for the 8051 core.
// Each port has an 8-bit output latch driven straight to the pins and a
// synchronised copy of its input pins. A read returns either the latch
// (read-modify-write) or the pins. Each port also has a change-detect flag
// that can raise an interrupt through a mask register. The block holds its
// state through short glitches on the reset line by using a filtered
// internal reset.
module sfr_port_bank #(
  parameter int         NUM_PORTS   = 4,
  parameter logic [7:0] BASE_ADDR   = 8'h80,
  parameter logic [7:0] ADDR_STRIDE = 8'h10,
  parameter logic [7:0] MASK_ADDR   = 8'hA8,
  parameter logic [7:0] FLAG_ADDR   = 8'hC0,
  parameter int         SYNC_STAGES = 2,
  parameter int         RST_HOLD    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             addr,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic                   rmw,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic                   rd_valid,
  output logic                   hit,
  input  logic [8*NUM_PORTS-1:0] pin_in,
  output logic [8*NUM_PORTS-1:0] pin_out,
  output logic                   irq
);

  localparam int         IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [3:0] HOLD     = 4'(RST_HOLD);
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  // Which register the current address selects.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PORT,
    SEL_MASK,
    SEL_FLAG
  } sel_e;

  // Port k's address. The arithmetic is 8-bit, so large strides wrap.
  function automatic logic [7:0] port_addr(input int k);
    logic [15:0] prod;
    prod = 16'(k) * 16'(ADDR_STRIDE);
    return BASE_ADDR + prod[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Internal signals
  // ---------------------------------------------------------------------------
  logic [3:0]                                rst_cnt_q;
  logic                                      irst;
  logic [2:0]                                arm_q;
  logic                                      armed;

  logic [SYNC_STAGES-1:0][NUM_PORTS-1:0][7:0] sync_q;
  logic [NUM_PORTS-1:0][7:0]                 sync_final;
  logic [NUM_PORTS-1:0][7:0]                 prev_q;
  logic [NUM_PORTS-1:0][7:0]                 latch_q;

  logic [NUM_PORTS-1:0]                      mask_q;
  logic [NUM_PORTS-1:0]                      flag_q;
  logic [NUM_PORTS-1:0]                      flag_next;
  logic [NUM_PORTS-1:0]                      change_set;

  sel_e                                      sel;
  logic [IDX_W-1:0]                          sel_idx;
  logic [7:0]                                read_val;

  // ---------------------------------------------------------------------------
  // Reset filter
  // ---------------------------------------------------------------------------
  // Count consecutive low cycles of reset. The count saturates at RST_HOLD,
  // and any high cycle clears it.
  // NOTE: state registers use non-blocking (<=) assignments, so every flop
  // samples the values from before the edge. Blocking assignments here would
  // create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt_q <= '0;
    end else if (rst_cnt_q != HOLD) begin
      rst_cnt_q <= rst_cnt_q + 4'd1;
    end
  end

  assign irst = (rst_cnt_q == HOLD);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  // The first match wins when addresses overlap. Ports are checked in
  // ascending order, then the mask register, then the flag register.
  // NOTE: every variable gets a default at the top of the block. This keeps
  // any path from leaving a variable unassigned, which would infer a latch.
  always_comb begin
    sel     = SEL_NONE;
    sel_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel == SEL_NONE && addr == port_addr(k)) begin
        sel     = SEL_PORT;
        sel_idx = IDX_W'(k);
      end
    end
    if (sel == SEL_NONE && addr == MASK_ADDR) begin
      sel = SEL_MASK;
    end else if (sel == SEL_NONE && addr == FLAG_ADDR) begin
      sel = SEL_FLAG;
    end
  end

  assign hit = (sel != SEL_NONE);

  // ---------------------------------------------------------------------------
  // Pin synchronisers and change detection
  // ---------------------------------------------------------------------------
  // Shift raw pins through SYNC_STAGES flops. The chain resets to all ones to
  // match the idle state of a quasi-bidirectional 8051 port.
  always_ff @(posedge clk) begin
    if (irst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
    end
  end

  assign sync_final = sync_q[SYNC_STAGES-1];

  // Keep the previous final-stage value so each port can see an edge.
  always_ff @(posedge clk) begin
    if (irst) begin
      prev_q <= '1;
    end else begin
      prev_q <= sync_final;
    end
  end

  // Arm counter. Detection stays off until real pin values have replaced the
  // all-ones reset pattern in both the final stage and the history register.
  always_ff @(posedge clk) begin
    if (irst) begin
      arm_q <= '0;
    end else if (arm_q != ARM_DONE) begin
      arm_q <= arm_q + 3'd1;
    end
  end

  assign armed = (arm_q == ARM_DONE);

  // A port raises a change request when any bit of its synchronised pins
  // differs from the previous cycle.
  always_comb begin
    change_set = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      change_set[k] = armed && (sync_final[k] != prev_q[k]);
    end
  end

  // ---------------------------------------------------------------------------
  // Output latches
  // ---------------------------------------------------------------------------
  // Port latch write. pin_out is a direct view of the latches.
  always_ff @(posedge clk) begin
    if (irst) begin
      latch_q <= '1;
    end else if (wr_en && sel == SEL_PORT) begin
      latch_q[sel_idx] <= wdata;
    end
  end

  assign pin_out = latch_q;

  // ---------------------------------------------------------------------------
  // Interrupt mask and change flags
  // ---------------------------------------------------------------------------
  // Mask write. Only the bits for ports that exist are stored.
  always_ff @(posedge clk) begin
    if (irst) begin
      mask_q <= '0;
    end else if (wr_en && sel == SEL_MASK) begin
      mask_q <= wdata[NUM_PORTS-1:0];
    end
  end

  // Next flag value. A write of 1 clears a flag first, and a change on the
  // same cycle then sets it again, so a new event is never lost.
  always_comb begin
    flag_next = flag_q;
    if (wr_en && sel == SEL_FLAG) begin
      flag_next = flag_next & ~wdata[NUM_PORTS-1:0];
    end
    flag_next = flag_next | change_set;
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (irst) begin
      flag_q <= '0;
    end else begin
      flag_q <= flag_next;
    end
  end

  // Registered interrupt request from the current flags and mask.
  always_ff @(posedge clk) begin
    if (irst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(flag_q & mask_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  // Read data mux. It uses pre-edge state, so a write to the same address in
  // the same cycle does not show in the returned value. Unmapped addresses
  // read as zero.
  always_comb begin
    read_val = 8'h00;
    case (sel)
      SEL_PORT: read_val = rmw ? latch_q[sel_idx] : sync_final[sel_idx];
      SEL_MASK: read_val = 8'(mask_q);
      SEL_FLAG: read_val = 8'(flag_q);
      default:  read_val = 8'h00;
    endcase
  end

  // Registered read response. The data holds its value between reads, and
  // rd_valid pulses once for each read strobe.
  always_ff @(posedge clk) begin
    if (irst) begin
      rdata    <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rdata <= read_val;
      end
    end
  end

endmodule

// File: tb/tb_sfr_port_bank.sv
// Self-checking bench for sfr_port_bank with the default parameters
// (4 ports at 0x80/0x90/0xA0/0xB0, mask at 0xA8, flags at 0xC0).
// Each read pushes its expected data into a queue. A monitor pops and
// compares an entry whenever rd_valid is seen.
module tb_sfr_port_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic        rmw;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rd_valid;
  logic        hit;
  logic [31:0] pin_in;
  logic [31:0] pin_out;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  sfr_port_bank dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .rmw      (rmw),
    .wdata    (wdata),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .hit      (hit),
    .pin_in   (pin_in),
    .pin_out  (pin_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic m,
                          input logic [7:0] expected, input string name);
    addr  = a;
    rmw   = m;
    rd_en = 1'b1;
    exp_q.push_back(expected);
    tag_q.push_back(name);
    tick();
    rd_en = 1'b0;
  endtask

  // Drive reset low for n cycles, then release it.
  task automatic pulse_reset(input int n);
    reset = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  // Monitor: each rd_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rdata %h with no read outstanding", rdata);
      end else begin
        logic [7:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (rdata !== e) begin
          n_fail++;
          $display("FAIL %s: got rdata %h, expected %h", t, rdata, e);
        end
      end
    end
  end

  // Watchdog: stop the run if it exceeds its time budget.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    addr   = 8'h00;
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    rmw    = 1'b0;
    wdata  = 8'h00;
    pin_in = 32'h0000_0000;
    repeat (2) tick();

    // Full-length reset, with the pins held at 0 through the release.
    pulse_reset(12);
    repeat (6) tick();
    check("rst_pin_out", pin_out, 32'hFFFF_FFFF);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    bus_read(8'hC0, 1'b0, 8'h00, "flags_after_arm_pins_low");

    // A 9-cycle reset pulse must not disturb the state.
    bus_write(8'h80, 8'h77);
    pulse_reset(9);
    tick();
    check("short_rst_pin_out0", {24'd0, pin_out[7:0]}, 32'h77);
    bus_read(8'h80, 1'b1, 8'h77, "short_rst_latch0");

    // Port write and read-modify-write readback.
    bus_write(8'h90, 8'h5A);
    check("wr_port1_pin_out", {24'd0, pin_out[15:8]}, 32'h5A);
    bus_read(8'h90, 1'b1, 8'h5A, "rd_port1_latch");

    // Pin read versus latch read, issued as back-to-back reads.
    bus_write(8'h80, 8'hFF);
    pin_in[7:0] = 8'h3C;
    repeat (3) tick();
    bus_read(8'h80, 1'b0, 8'h3C, "rd_port0_pins");
    bus_read(8'h80, 1'b1, 8'hFF, "rd_port0_latch");
    bus_read(8'hC0, 1'b0, 8'h01, "flag0_from_pin_change");
    check("irq_masked_off", {31'd0, irq}, 32'd0);
    bus_write(8'hC0, 8'hFF);
    bus_read(8'hC0, 1'b0, 8'h00, "flags_cleared");

    // Change detect on port 2 with the mask set. Check the exact latency.
    bus_write(8'hA8, 8'h04);
    bus_read(8'hA8, 1'b0, 8'h04, "mask_readback");
    pin_in[16] = 1'b1;
    repeat (3) tick();
    check("irq_before_flag_to_irq", {31'd0, irq}, 32'd0);
    tick();
    check("irq_set_port2", {31'd0, irq}, 32'd1);
    bus_read(8'hC0, 1'b0, 8'h04, "flag2_set");
    bus_write(8'hC0, 8'h04);
    tick();
    check("irq_after_w1c", {31'd0, irq}, 32'd0);

    // Second toggle: the change lands on the same edge as the W1C, so the set wins.
    pin_in[16] = 1'b0;
    repeat (2) tick();
    bus_write(8'hC0, 8'h04);
    bus_read(8'hC0, 1'b0, 8'h04, "flag2_set_beats_clear");
    check("irq_set_beats_clear", {31'd0, irq}, 32'd1);
    bus_write(8'hC0, 8'h04);
    tick();
    check("irq_after_second_w1c", {31'd0, irq}, 32'd0);

    // Unmapped address.
    addr = 8'h85;
    #1;
    check("hit_unmapped", {31'd0, hit}, 32'd0);
    addr = 8'hA8;
    #1;
    check("hit_mask", {31'd0, hit}, 32'd1);
    bus_read(8'h85, 1'b1, 8'h00, "rd_unmapped");
    bus_write(8'h85, 8'h00);
    check("wr_unmapped_pin_out", pin_out, 32'hFFFF_5AFF);
    bus_read(8'h90, 1'b1, 8'h5A, "port1_after_unmapped_wr");

    // Simultaneous read and write to port 2: the read returns the old latch.
    addr  = 8'hA0;
    rmw   = 1'b1;
    wdata = 8'h11;
    rd_en = 1'b1;
    wr_en = 1'b1;
    exp_q.push_back(8'hFF);
    tag_q.push_back("rdwr_port2_old_value");
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("rdwr_port2_pin_out", {24'd0, pin_out[23:16]}, 32'h11);
    bus_read(8'hA0, 1'b1, 8'h11, "rdwr_port2_new_latch");

    // Mask bits above NUM_PORTS read as zero.
    bus_write(8'hA8, 8'hFF);
    bus_read(8'hA8, 1'b0, 8'h0F, "mask_upper_bits_zero");
    check("irq_no_flags", {31'd0, irq}, 32'd0);

    // Second full reset. Pins differ from the all-ones reset pattern, and the
    // arming delay must keep that difference from setting a flag.
    pulse_reset(12);
    repeat (6) tick();
    check("rst2_pin_out", pin_out, 32'hFFFF_FFFF);
    bus_read(8'hA8, 1'b0, 8'h00, "rst2_mask");
    bus_read(8'hC0, 1'b0, 8'h00, "rst2_flags_after_arm");
    bus_read(8'hA0, 1'b1, 8'hFF, "rst2_latch2");
    bus_read(8'h80, 1'b0, 8'h3C, "rst2_port0_pins");

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
